instr_loader: RTL
=================

# instr_loader

Program loader for the 9-bit processor's instruction memory. Accepts a length-prefixed burst of 9-bit instruction words over a valid/ready stream, writes them into instruction memory at consecutive addresses from a base address, then pulses the processor's start input with the base address as the start address.

## Interface

**Parameters**
- ADDR_W, 8: instruction memory address width; addresses wrap modulo 2^ADDR_W.
- INSTR_W, 9: instruction word width.

**Ports**
- CLK, in, 1: single clock; all logic on the rising edge.
- RST_N, in, 1: reset; asynchronous, active-low.
- LoadReq, in, 1: level; sampled only in IDLE. Starts a load.
- LoadBase, in, ADDR_W: first write address. Sampled with LoadReq.
- LoadLen, in, ADDR_W+1: word count, valid range 1..2^ADDR_W. Sampled with LoadReq.
- InValid, in, 1: stream word valid.
- InData, in, INSTR_W: stream word.
- InReady, out, 1: loader accepts a word. A beat transfers on any cycle where InValid=1 and InReady=1.
- WrEn, out, 1: instruction memory write strobe.
- WrAddr, out, ADDR_W: write address.
- WrData, out, INSTR_W: write data.
- Start, out, 1: one-cycle pulse to the processor start input.
- StartAddr, out, ADDR_W: latched LoadBase. Held stable from acceptance of LoadReq until the next accepted LoadReq.
- Busy, out, 1: high in every state except IDLE.
- Done, out, 1: one-cycle pulse on successful completion.
- Error, out, 1: one-cycle pulse on a rejected request or a failed checksum.

## Operation

- **States:** IDLE, LOAD, FLUSH, CHECK (present only when the checksum feature is built), LAUNCH.
- **IDLE**
  - InReady=0.
  - On LoadReq=1 with LoadLen in range: latch base and length, clear the word counter, go to LOAD.
  - On LoadReq=1 with LoadLen=0 or LoadLen>2^ADDR_W: pulse Error next cycle, stay in IDLE, do not update StartAddr.
- **LOAD**
  - InReady=1.
  - Each accepted beat registers WrEn=1, WrAddr=(base+count) mod 2^ADDR_W, WrData=InData, then increments count.
  - After the beat where count reaches len-1 is accepted, go to FLUSH.
  - LoadReq is ignored outside IDLE.
- **FLUSH**
  - InReady=0. The final WrEn is visible this cycle.
  - Without the checksum feature, go to LAUNCH. With it, go to CHECK.
- **LAUNCH**
  - Start=1 and Done=1 for exactly this cycle, then go to IDLE.
- **Counter width:** ADDR_W+1 bits, so a full 2^ADDR_W-word load is supported. Address arithmetic drops the carry. Example: base 0xF0 with len 32 writes 0xF0..0xFF, then 0x00..0x0F.
- **Reset:** any state returns to IDLE. A load in progress is abandoned with no Start, Done or Error. Words already written stay in memory.

## Timing

- **Reset values:** InReady, WrEn, Start, Busy, Done and Error are 0. WrAddr, WrData and StartAddr are 0.
- **Request acceptance:** LoadReq accepted at edge t gives Busy=1 and InReady=1 from cycle t+1.
- **Write latency:** a beat accepted at edge t gives WrEn, WrAddr and WrData for cycle t+1 only. WrEn is 0 in every other cycle.
- **Throughput:** one word per cycle. The stream may stall (InValid=0) at any point with no effect except delay.
- **Completion:** last beat at edge t gives FLUSH and the last WrEn in cycle t+1, then Start and Done in cycle t+2, then IDLE with Busy=0 in cycle t+3.
- **Back-to-back loads:** a new LoadReq is accepted at the earliest at the edge ending cycle t+3.
- **Rejected request:** LoadReq rejected at edge t gives Error=1 in cycle t+1 only.

## Configuration

- **LOADER_CHECKSUM_EN defined:**
  - CHECK state exists with InReady=1.
  - The loader keeps a running XOR of all INSTR_W-bit words written.
  - One extra stream beat, the checksum word, is accepted in CHECK and never written to memory.
  - A match goes to LAUNCH in the next cycle.
  - A mismatch pulses Error in the next cycle, then IDLE, with no Start and no Done.
- **LOADER_CHECKSUM_EN not defined:**
  - No CHECK state and no extra beat.
  - FLUSH goes directly to LAUNCH.

## Test plan

- **Basic load:** reset, then LoadReq with base 0x10, len 3, words 0x1A5, 0x003, 0x1FF, continuous valid -> WrEn cycles at addresses 0x10, 0x11, 0x12 with those data; Start=1 with StartAddr=0x10 two cycles after the last beat; Busy=0 one cycle later.
- **Wrap and stall:** base 0xFE, len 4, InValid toggling every cycle -> writes to 0xFE, 0xFF, 0x00, 0x01 in order; no write during stall cycles; exactly one Start.
- **Length bounds:** LoadLen=0 -> single Error pulse, no WrEn, StartAddr unchanged. LoadLen=256 with base 0x00 -> 256 writes covering 0x00..0xFF, then Start.
- **Reset mid-load:** len 8, assert RST_N=0 after 4 beats -> all outputs 0 immediately; no Start or Done afterwards; next LoadReq works normally.
- **Ignored request:** hold LoadReq=1 throughout a len-2 load -> requests during Busy are ignored; a new load is accepted only in IDLE, in the cycle after Busy falls.
- **Checksum (LOADER_CHECKSUM_EN):** words 0x0F0, 0x00F, then checksum 0x0FF -> Start and Done pulse. The same words with checksum 0x000 -> Error pulse, no Start; the checksum beat produces no WrEn in either case.

Source files
------------

// File: rtl/instr_loader_if.sv
// instr_loader_if: request, stream and memory-write bundle for instr_loader.
//   slave  : loader side (takes request + stream, drives ready, write, status)
//   master : host / testbench side
// Signals:
//   LoadReq, LoadBase, LoadLen   load request
//   InValid, InData, InReady     instruction word stream (valid/ready)
//   WrEn, WrAddr, WrData         instruction memory write port
//   Start, StartAddr             processor launch
//   Busy, Done, Error            status
interface instr_loader_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
) ();
    logic               LoadReq;
    logic [ADDR_W-1:0]  LoadBase;
    logic [ADDR_W:0]    LoadLen;
    logic               InValid;
    logic [INSTR_W-1:0] InData;
    logic               InReady;
    logic               WrEn;
    logic [ADDR_W-1:0]  WrAddr;
    logic [INSTR_W-1:0] WrData;
    logic               Start;
    logic [ADDR_W-1:0]  StartAddr;
    logic               Busy;
    logic               Done;
    logic               Error;

    modport slave (
        input  LoadReq, LoadBase, LoadLen, InValid, InData,
        output InReady, WrEn, WrAddr, WrData, Start, StartAddr, Busy, Done, Error
    );

    modport master (
        output LoadReq, LoadBase, LoadLen, InValid, InData,
        input  InReady, WrEn, WrAddr, WrData, Start, StartAddr, Busy, Done, Error
    );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: loads a length-prefixed burst of instruction words into
// instruction memory starting at a base address, then pulses Start with the
// base address as the processor start address.
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    instr_loader_if.slave (request, stream, memory write, status)
// Build option:
//   LOADER_CHECKSUM_EN  adds a CHECK state that accepts one extra stream word
//                       and compares it against the XOR of all written words.
module instr_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
) (
    input  logic          CLK,
    input  logic          RST_N,
    instr_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_LAUNCH
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W:0]    len_q, len_d;
    // One bit wider than the address so a full 2^ADDR_W load can be counted.
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
    logic               err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] csum_q, csum_d;
`endif

    logic in_ready;
    logic beat;
    logic len_ok;

`ifdef LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign in_ready = (state_q == S_LOAD);
`endif
    assign beat   = bus.InValid && in_ready;
    assign len_ok = (bus.LoadLen != '0) && (bus.LoadLen <= LEN_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            start_addr_q <= '0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            start_addr_q <= start_addr_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        start_addr_d = start_addr_q;
        err_d        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.LoadReq) begin
                    if (len_ok) begin
                        base_d       = bus.LoadBase;
                        len_d        = bus.LoadLen;
                        cnt_d        = '0;
                        start_addr_d = bus.LoadBase;
`ifdef LOADER_CHECKSUM_EN
                        csum_d       = '0;
`endif
                        state_d      = S_LOAD;
                    end else begin
                        // Rejected: StartAddr keeps the previous load's base.
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    // Carry out of the address is dropped, giving the wrap.
                    wr_addr_d = base_q + cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.InData;
                    cnt_d     = cnt_q + LEN_ONE;
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ bus.InData;
`endif
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CHECK;
`else
                state_d = S_LAUNCH;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The checksum word is consumed but never written.
                if (beat) begin
                    if (bus.InData == csum_q) begin
                        state_d = S_LAUNCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_LAUNCH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.InReady   = in_ready;
    assign bus.WrEn      = wr_en_q;
    assign bus.WrAddr    = wr_addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.Start     = (state_q == S_LAUNCH);
    assign bus.Done      = (state_q == S_LAUNCH);
    assign bus.StartAddr = start_addr_q;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Error     = err_q;

endmodule
